present80_dec_core: RTL and testbench
=====================================

PRESENT80_DEC_CORE -- requirements
Module: present80_dec_core

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-003 SHALL have port: start  input  1  request one decryption; sampled only while idle.
REQ-004 SHALL have port: ct  input  64  ciphertext; bit 63 = MSB of byte 0.
REQ-005 SHALL have port: key  input  80  cipher key; bit 79 = MSB of byte 0.
REQ-006 SHALL have port: busy  output  1  high while a decryption is in progress.
REQ-007 SHALL have port: done  output  1  one-cycle pulse when pt is valid.
REQ-008 SHALL have port: pt  output  64  recovered plaintext, registered.

Function
REQ-009 SHALL implement the inverse of PRESENT-80 with 31 rounds, the standard S-box/pLayer, and the standard 80-bit key schedule.
- Forward key update: rotate left 61, S-box on bits [79:76], XOR 5-bit round counter into bits [19:15].
- Round key = key register [79:16].
REQ-010 SHALL use the state machine IDLE -> KEYFWD -> ROUND -> IDLE, one transition or iteration per clock.
REQ-011 In IDLE, start=1 SHALL latch ct into the data register and key into the key register, set rc=1, and enter KEYFWD; busy rises the next cycle.
REQ-012 In KEYFWD, each cycle SHALL apply the forward key update with rc and then increment rc, for 31 cycles.
REQ-013 The final KEYFWD cycle SHALL also XOR the updated key [79:16] (K32) into the data register, set rc=31, and enter ROUND.
REQ-014 In ROUND, each cycle SHALL:
- Compute the inverse key update with rc: XOR rc into [19:15], inverse S-box on [79:76], rotate right 61.
- Set data <= invS(invP(data)) XOR new_key[79:16].
- Decrement rc.
- Run for 31 cycles.
REQ-015 The final ROUND cycle SHALL load pt with the data result, pulse done=1 for exactly one cycle, drop busy in that same edge, and return to IDLE.
REQ-016 Latency SHALL be 62 clocks, from the edge sampling start to the edge asserting done.
REQ-017 start while busy=1 SHALL be ignored; ct and key changes while busy SHALL NOT affect the result.
REQ-018 start asserted in the same cycle that done is asserted SHALL be accepted, giving back-to-back operation.
REQ-019 pt SHALL hold its last value until the next completion; done SHALL be 0 whenever busy=1.
REQ-020 The 5-bit round counter SHALL never wrap: rc stays in 1..31 in both phases.

Reset
REQ-021 rst=1 SHALL force the following on the next edge, overriding start:
- state=IDLE, busy=0, done=0, pt=64'h0;
- data, key and rc registers cleared.
REQ-022 rst asserted mid-operation SHALL abort the operation with no done pulse; the first start after rst is released SHALL run the full 62-cycle sequence.

Configuration
REQ-023 Macro PRESENT_DEC_KEYCACHE_EN SHALL control the key cache.
- Defined: the core stores the last latched key and its K32 register value with a valid flag (cleared by rst). A start whose key equals the cached key with the flag valid SHALL skip KEYFWD: K32 is XORed into data and the core enters ROUND directly, giving a latency of 31 clocks. Other keys run the full sequence and refresh the cache at the end of KEYFWD.
- Undefined: no cache storage exists, and every operation takes 62 clocks.

Verification
REQ-024 key=80'h0, ct=64'h5579C1387B228445, start pulse -> done exactly 62 cycles later, pt=64'h0.
REQ-025 key=80'hFFFF_FFFFFFFF_FFFFFFFF, ct=64'hE72C46C0F5945049 -> pt=64'h0; then ct=64'h3333DCD3213210D2 with the same key -> pt=64'hFFFFFFFFFFFFFFFF (31 cycles with PRESENT_DEC_KEYCACHE_EN, else 62).
REQ-026 key=80'h0, ct=64'hA112FFC72F68417B; pulse start again at cycle 10 with different ct -> second start ignored, pt=64'hFFFFFFFFFFFFFFFF, single done pulse.
REQ-027 Start an operation, assert rst at cycle 40 for one cycle -> busy=0, done=0, pt=0 next cycle; no done follows; a new start then completes in full latency with correct pt.
REQ-028 Hold start high continuously with fixed inputs -> done pulses every 63 cycles, busy low exactly one cycle between operations, pt correct each time.

Source files
------------

// File: rtl/present80_dec_core.sv
// present80_dec_core: iterative PRESENT-80 decryption, one key-schedule step or inverse round per clock.
// Optional key cache (PRESENT_DEC_KEYCACHE_EN) skips the forward key schedule when the key repeats.
module present80_dec_core (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [63:0] ct,
    input  logic [79:0] key,
    output logic        busy,
    output logic        done,
    output logic [63:0] pt
);
    localparam logic [63:0] SBOX     = 64'h21748FE3DA09B65C;
    localparam logic [63:0] SBOX_INV = 64'hA970364BD21C8FE5;
    typedef enum logic [1:0] {IDLE, KEYFWD, ROUND} state_t;
    state_t state_q, state_d;
    logic [63:0] data_q, data_d, pt_q, pt_d, dinv_p, dinv_s, dnext;
    logic [79:0] key_q, key_d, kr, kfwd, kx, kinv;
    logic [4:0]  rc_q, rc_d;
    logic        done_q, done_d;
`ifdef PRESENT_DEC_KEYCACHE_EN
    logic [79:0] ckey_q, ckey_d, ck32_q, ck32_d;
    logic        cv_q, cv_d;
`endif
    assign kr   = {key_q[18:0], key_q[79:19]};
    assign kfwd = {SBOX[{kr[79:76], 2'b00} +: 4], kr[75:20], kr[19:15] ^ rc_q, kr[14:0]};
    assign kx   = {key_q[79:20], key_q[19:15] ^ rc_q, key_q[14:0]};
    assign kinv = {kx[60:0], SBOX_INV[{kx[79:76], 2'b00} +: 4], kx[75:61]};
    // Inverse pLayer: output bit i takes the bit the forward pLayer moved i to.
    for (genvar i = 0; i < 63; i++) begin : g_ip
        assign dinv_p[i] = data_q[(16 * i) % 63];
    end
    assign dinv_p[63] = data_q[63];
    for (genvar i = 0; i < 16; i++) begin : g_is
        assign dinv_s[4*i +: 4] = SBOX_INV[{dinv_p[4*i +: 4], 2'b00} +: 4];
    end
    assign dnext = dinv_s ^ kinv[79:16];
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        key_d   = key_q;
        rc_d    = rc_q;
        pt_d    = pt_q;
        done_d  = 1'b0;
`ifdef PRESENT_DEC_KEYCACHE_EN
        ckey_d  = ckey_q;
        ck32_d  = ck32_q;
        cv_d    = cv_q;
`endif
        case (state_q)
            IDLE: if (start) begin
                data_d  = ct;
                key_d   = key;
                rc_d    = 5'd1;
                state_d = KEYFWD;
`ifdef PRESENT_DEC_KEYCACHE_EN
                ckey_d  = key;
                cv_d    = cv_q && (key == ckey_q);
                if (cv_d) begin
                    data_d  = ct ^ ck32_q[79:16];
                    key_d   = ck32_q;
                    rc_d    = 5'd31;
                    state_d = ROUND;
                end
`endif
            end
            KEYFWD: begin
                key_d = kfwd;
                rc_d  = rc_q + 5'd1;
                if (rc_q == 5'd31) begin
                    data_d  = data_q ^ kfwd[79:16];
                    rc_d    = 5'd31;
                    state_d = ROUND;
`ifdef PRESENT_DEC_KEYCACHE_EN
                    ck32_d  = kfwd;
                    cv_d    = 1'b1;
`endif
                end
            end
            ROUND: begin
                key_d  = kinv;
                data_d = dnext;
                rc_d   = rc_q - 5'd1;
                if (rc_q == 5'd1) begin
                    rc_d    = 5'd1;
                    pt_d    = dnext;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            key_q   <= '0;
            rc_q    <= '0;
            pt_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            key_q   <= key_d;
            rc_q    <= rc_d;
            pt_q    <= pt_d;
            done_q  <= done_d;
        end
    end
`ifdef PRESENT_DEC_KEYCACHE_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cv_q   <= 1'b0;
            ckey_q <= '0;
            ck32_q <= '0;
        end else begin
            cv_q   <= cv_d;
            ckey_q <= ckey_d;
            ck32_q <= ck32_d;
        end
    end
`endif
    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign pt   = pt_q;
endmodule

// File: tb/tb_present80_dec_core.sv
// tb_present80_dec_core: directed known-answer vectors, latency, abort and back-to-back checks.
module tb_present80_dec_core;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [63:0] ct = '0;
    logic [79:0] key = '0;
    logic        busy, done;
    logic [63:0] pt;
    int vec_cnt = 0;
    int err_cnt = 0;
`ifdef PRESENT_DEC_KEYCACHE_EN
    localparam int LAT_HIT = 31;
    localparam int GAP_HIT = 32;
`else
    localparam int LAT_HIT = 62;
    localparam int GAP_HIT = 63;
`endif
    localparam logic [79:0] K0 = 80'h0;
    localparam logic [79:0] KF = 80'hFFFF_FFFFFFFF_FFFFFFFF;
    localparam logic [63:0] ONES = 64'hFFFFFFFFFFFFFFFF;

    present80_dec_core dut (
        .clk(clk), .rst(rst), .start(start), .ct(ct), .key(key),
        .busy(busy), .done(done), .pt(pt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic pulse_rst();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // poke >= 0: re-pulse start with altered ct/key after that many edges
    task automatic run_op(input string tag, input logic [63:0] c, input logic [79:0] k,
                          input logic [63:0] exp, input int lat, input int poke);
        int n;
        int extra;
        @(negedge clk);
        ct = c;
        key = k;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, " busy"}, 64'(busy), 64'd1);
        n = 0;
        while (!done && n < 200) begin
            if (n == poke) begin
                start = 1'b1;
                ct = ~c;
                key = ~k;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            n++;
            if (busy && done) check({tag, " done while busy"}, 64'(done), 64'd0);
        end
        start = 1'b0;
        check({tag, " latency"}, 64'(n), 64'(lat));
        check({tag, " pt"}, pt, exp);
        extra = 0;
        repeat (70) begin
            @(negedge clk);
            if (done) extra++;
        end
        check({tag, " extra done"}, 64'(extra), 64'd0);
    endtask

    initial begin
        int n;
        int k;
        int last;
        int lows;
        int dn;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset pt", pt, 64'd0);

        run_op("kat0", 64'h5579C1387B228445, K0, 64'h0, 62, -1);
        run_op("katF", 64'hE72C46C0F5945049, KF, 64'h0, 62, -1);
        run_op("katF reuse", 64'h3333DCD3213210D2, KF, ONES, LAT_HIT, -1);
        run_op("ignore start", 64'hA112FFC72F68417B, K0, ONES, 62, 10);

        pulse_rst();
        @(negedge clk);
        ct = 64'hA112FFC72F68417B;
        key = K0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (39) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort busy", 64'(busy), 64'd0);
        check("abort done", 64'(done), 64'd0);
        check("abort pt", pt, 64'd0);
        dn = 0;
        repeat (80) begin
            @(negedge clk);
            if (done) dn++;
        end
        check("abort no done", 64'(dn), 64'd0);
        run_op("after abort", 64'hA112FFC72F68417B, K0, ONES, 62, -1);

        pulse_rst();
        @(negedge clk);
        ct = 64'h3333DCD3213210D2;
        key = KF;
        start = 1'b1;
        n = 0;
        k = 0;
        last = 0;
        lows = 0;
        while (k < 4 && n < 400) begin
            @(negedge clk);
            n++;
            if (!busy) lows++;
            if (done) begin
                check("b2b pt", pt, ONES);
                check("b2b gap", 64'(n - last), 64'(k == 0 ? 63 : GAP_HIT));
                check("b2b busy low", 64'(lows), 64'd1);
                lows = 0;
                last = n;
                k++;
            end
        end
        start = 1'b0;
        check("b2b done count", 64'(k), 64'd4);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
